// File: rtl/reaction_timer_multi.sv
`timescale 1ns/1ps
// reaction_timer_multi: multi-player reaction round (delay, stimulus, per-player timing),
// with false-start and timeout flags, winner selection and per-player best times.
module reaction_timer_multi #(
    parameter int NUM_PLAYERS = 2,
    parameter int TIME_WIDTH  = 14,
    parameter int TIMEOUT_MS  = 9999,
    parameter int WIN_W       = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              rising_edge_1khz,
    input  logic                              start,
    input  logic [TIME_WIDTH-1:0]             delay_ms,
    input  logic [NUM_PLAYERS-1:0]            buttons,
    output logic                              stimulus,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_PLAYERS*TIME_WIDTH-1:0] reaction_times,
    output logic [NUM_PLAYERS-1:0]            responded,
    output logic [NUM_PLAYERS-1:0]            false_start,
    output logic [NUM_PLAYERS-1:0]            timed_out,
    output logic [WIN_W-1:0]                  winner,
    output logic                              winner_valid,
    output logic [NUM_PLAYERS*TIME_WIDTH-1:0] best_times
);
    localparam int N = NUM_PLAYERS;
    localparam int W = TIME_WIDTH;
    localparam logic [W-1:0] TMO = W'(TIMEOUT_MS);

    typedef enum logic [1:0] {IDLE, WAIT, TEST, DONE} state_t;
    state_t state, state_n;

    // one counter: countdown while waiting, elapsed milliseconds while testing
    logic [W-1:0]   count;
    logic [N-1:0]   buttons_q, press, fs_n, new_resp, resp_n, to_set;
    logic [N*W-1:0] times_n;
    logic [WIN_W-1:0] win_n;
    logic [W-1:0]   win_t;
    logic           launch, wait_end, all_resp, expire, enter_done, found;

    assign press      = buttons & ~buttons_q;
    assign launch     = start && (state == IDLE || state == DONE);
    assign wait_end   = count == '0 || (rising_edge_1khz && count == W'(1));
    assign fs_n       = false_start | (state == WAIT ? press : '0);
    assign new_resp   = state == TEST ? press & ~false_start & ~responded : '0;
    assign resp_n     = responded | new_resp;
    assign all_resp   = &(resp_n | false_start);
    assign expire     = state == TEST && rising_edge_1khz && count == TMO && !all_resp;
    assign to_set     = expire ? ~false_start & ~resp_n : '0;
    assign enter_done = state_n == DONE && state != DONE;

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (launch ? WAIT : IDLE) :
                  state == WAIT ? (&fs_n ? DONE : wait_end ? TEST : WAIT) :
                  state == TEST ? (all_resp || expire ? DONE : TEST) :
                                  (launch ? WAIT : DONE);
    end

    always_comb begin
        stimulus = state == TEST;
        busy     = state == WAIT || state == TEST;
        done     = state == DONE;
    end

    always_comb begin
        times_n = reaction_times;
        for (int i = 0; i < N; i++)
            if (new_resp[i])
                times_n[i*W +: W] = count;
            else if (to_set[i])
                times_n[i*W +: W] = TMO;
    end

    // strict less-than keeps the lowest index on ties
    always_comb begin
        win_n = '0;
        win_t = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++)
            if (resp_n[i] && (!found || times_n[i*W +: W] < win_t)) begin
                win_n = WIN_W'(i);
                win_t = times_n[i*W +: W];
                found = 1'b1;
            end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            reaction_times <= '0;
            responded      <= '0;
            false_start    <= '0;
            timed_out      <= '0;
            winner         <= '0;
            winner_valid   <= 1'b0;
            best_times     <= '1;
            buttons_q      <= '0;
        end else begin
            // history cleared on start so a button already held counts as a press
            buttons_q <= launch ? '0 : buttons;
            if (launch) begin
                count          <= delay_ms;
                reaction_times <= '0;
                responded      <= '0;
                false_start    <= '0;
                timed_out      <= '0;
                winner         <= '0;
                winner_valid   <= 1'b0;
            end else begin
                if (state == WAIT)
                    count <= wait_end ? '0 : count - W'(rising_edge_1khz);
                if (state == TEST)
                    count <= count + W'(rising_edge_1khz && count != TMO);
                false_start    <= fs_n;
                responded      <= resp_n;
                timed_out      <= timed_out | to_set;
                reaction_times <= times_n;
                if (enter_done) begin
                    winner       <= win_n;
                    winner_valid <= |resp_n;
                    for (int i = 0; i < N; i++)
                        if (resp_n[i] && times_n[i*W +: W] < best_times[i*W +: W])
                            best_times[i*W +: W] <= times_n[i*W +: W];
                end
            end
        end
    end
endmodule

// File: tb/tb_reaction_timer_multi.sv
`timescale 1ns/1ps
// tb_reaction_timer_multi: randomized rounds checked by a scoreboard fed from a
// schedule-level reference model; a monitor compares results whenever done rises.
module tb_reaction_timer_multi;
    localparam int NP = 2;
    localparam int TW = 14;
    localparam int TO = 20;
    localparam int WW = 3;

    logic clk = 0, rst = 1, tick = 0, start = 0;
    logic [TW-1:0] delay = '0;
    logic [NP-1:0] buttons = '0;
    logic stimulus, busy, done, winner_valid;
    logic [NP*TW-1:0] reaction_times, best_times;
    logic [NP-1:0] responded, false_start, timed_out;
    logic [WW-1:0] winner;

    reaction_timer_multi #(.NUM_PLAYERS(NP), .TIME_WIDTH(TW), .TIMEOUT_MS(TO), .WIN_W(WW)) dut (
        .clock(clk), .reset(rst), .rising_edge_1khz(tick), .start(start), .delay_ms(delay),
        .buttons(buttons), .stimulus(stimulus), .busy(busy), .done(done),
        .reaction_times(reaction_times), .responded(responded), .false_start(false_start),
        .timed_out(timed_out), .winner(winner), .winner_valid(winner_valid), .best_times(best_times)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP*TW-1:0] times;
        logic [NP-1:0]    resp, fs, to;
        logic [WW-1:0]    win;
        logic             wv;
        logic [NP*TW-1:0] best;
    } exp_t;

    exp_t q[$];
    int passed = 0, total = 0;

    // round schedule: kind 0 = false start, 1 = responds at elapsed pe, 2 = never presses
    int kind[NP], pe[NP], fsk[NP];
    bit pt[NP];
    logic [NP-1:0] held = '0;
    logic [TW-1:0] best_m[NP];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit all_fs();
        for (int i = 0; i < NP; i++) if (kind[i] != 0) return 0;
        return 1;
    endfunction

    task automatic build_expect();
        exp_t x;
        int bi;
        x = '0;
        bi = -1;
        for (int i = 0; i < NP; i++) begin
            if (kind[i] == 0) x.fs[i] = 1'b1;
            else if (kind[i] == 1) begin
                x.resp[i] = 1'b1;
                x.times[i*TW +: TW] = TW'(pe[i]);
                if (bi < 0 || pe[i] < pe[bi]) bi = i;
                if (TW'(pe[i]) < best_m[i]) best_m[i] = TW'(pe[i]);
            end else begin
                x.to[i] = 1'b1;
                x.times[i*TW +: TW] = TW'(TO);
            end
        end
        x.wv  = bi >= 0;
        x.win = bi >= 0 ? WW'(bi) : '0;
        for (int i = 0; i < NP; i++) x.best[i*TW +: TW] = best_m[i];
        q.push_back(x);
    endtask

    logic prev_done = 0;
    always @(negedge clk) begin
        if (rst) prev_done = 0;
        else begin
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL done_unexpected: got done=1 expected no round pending");
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("reaction_times", 64'(reaction_times), 64'(x.times));
                    chk("responded", 64'(responded), 64'(x.resp));
                    chk("false_start", 64'(false_start), 64'(x.fs));
                    chk("timed_out", 64'(timed_out), 64'(x.to));
                    chk("winner_valid", 64'(winner_valid), 64'(x.wv));
                    if (x.wv) chk("winner", 64'(winner), 64'(x.win));
                    chk("best_times", 64'(best_times), 64'(x.best));
                end
            end
            prev_done = done;
        end
    end

    task automatic run_round(input int d, input bit start_in_test);
        logic [NP-1:0] btn;
        bit afs;
        afs = all_fs();
        btn = held;
        build_expect();
        @(negedge clk);
        start = 1; delay = TW'(d); buttons = btn; tick = 0;
        @(negedge clk);
        start = 0;
        chk("wait_busy_stim", 64'({busy, stimulus}), 64'(2'b10));
        for (int k = 0; k < d; k++) begin
            for (int i = 0; i < NP; i++) if (kind[i] == 0 && fsk[i] == k) btn[i] = 1'b1;
            buttons = btn;
            @(negedge clk);
            @(negedge clk);
            tick = 1;
            @(negedge clk);
            tick = 0;
        end
        if (d == 0) @(negedge clk);
        if (!afs) chk("stimulus_on_test", 64'({busy, stimulus}), 64'(2'b11));
        for (int e = 0; e <= TO; e++) begin
            for (int i = 0; i < NP; i++) if (kind[i] == 1 && pe[i] == e && !pt[i]) btn[i] = 1'b1;
            buttons = btn;
            start = start_in_test && e == 2;
            @(negedge clk);
            start = 0;
            for (int i = 0; i < NP; i++) if (kind[i] == 1 && pe[i] == e && pt[i]) btn[i] = 1'b1;
            buttons = btn;
            tick = 1;
            @(negedge clk);
            tick = 0;
        end
        @(negedge clk);
        chk("round_done", 64'({done, busy}), 64'(2'b10));
        buttons = '0;
        held = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_p(input int i, input int kd, input int e, input bit t, input int k);
        kind[i] = kd; pe[i] = e; pt[i] = t; fsk[i] = k;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_flags"}, 64'({stimulus, busy, done, winner_valid}), 64'(0));
        chk({nm, "_results"}, 64'({reaction_times, responded, false_start, timed_out, winner}), 64'(0));
        chk({nm, "_best"}, 64'(best_times), 64'({NP*TW{1'b1}}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NP; i++) best_m[i] = '1;
        repeat (3) @(negedge clk);
        rst = 0;
        check_reset_state("reset");
        // best tracking for P0: 9, 15, 6 (the last with no delay)
        set_p(0, 1, 9, 0, 0);  set_p(1, 2, 0, 0, 0); run_round(3, 0);
        set_p(0, 1, 15, 1, 0); set_p(1, 2, 0, 0, 0); run_round(2, 0);
        set_p(0, 1, 6, 0, 0);  set_p(1, 2, 0, 0, 0); run_round(0, 0);
        // nominal
        set_p(0, 1, 7, 0, 0);  set_p(1, 1, 12, 1, 0); run_round(5, 0);
        // single false start, then both false-start
        set_p(0, 1, 3, 0, 0);  set_p(1, 0, 0, 0, 1); run_round(4, 0);
        set_p(0, 0, 0, 0, 0);  set_p(1, 0, 0, 0, 2); run_round(3, 0);
        // nobody presses, then press on the final tick
        set_p(0, 2, 0, 0, 0);  set_p(1, 2, 0, 0, 0); run_round(2, 0);
        set_p(0, 1, TO, 1, 0); set_p(1, 2, 0, 0, 0); run_round(1, 0);
        // tie on a tick, with a start pulse mid-test
        set_p(0, 1, 4, 1, 0);  set_p(1, 1, 4, 1, 0); run_round(2, 1);
        // reset while testing at elapsed 8, button held through it
        @(negedge clk);
        start = 1; delay = TW'(1);
        @(negedge clk); start = 0;
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk); tick = 1;
            @(negedge clk); tick = 0;
        end
        chk("pre_reset_test", 64'({busy, stimulus}), 64'(2'b11));
        rst = 1; buttons = 2'b01;
        @(negedge clk);
        rst = 0;
        check_reset_state("mid_reset");
        for (int i = 0; i < NP; i++) best_m[i] = '1;
        held = 2'b01;
        set_p(0, 0, 0, 0, 0);  set_p(1, 1, 3, 0, 0); run_round(2, 0);
        // random rounds
        for (int r = 0; r < 25; r++) begin
            int d;
            d = int'($urandom_range(0, 6));
            for (int i = 0; i < NP; i++) begin
                int c;
                c = int'($urandom_range(0, 9));
                if (c < 2 && d > 0) set_p(i, 0, 0, 0, int'($urandom_range(0, d - 1)));
                else if (c < 4) set_p(i, 2, 0, 0, 0);
                else set_p(i, 1, int'($urandom_range(0, TO)), 1'($urandom_range(0, 1)), 0);
            end
            run_round(d, 0);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
